// File: rtl/pipe_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry first-word-fall-through FIFO of {pc4, instr} pairs.
// A flush empties the queue in one cycle; an empty head reads as a NOP (all zeros).

module pipe_fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] count
);
    // Occupancy must never exceed the storage size.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CW'(DEPTH));
        end
    end
endmodule

module pipe_fetch_queue #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_pc4,
    input  logic [DW-1:0] in_instr,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_pc4,
    output logic [DW-1:0] out_instr,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] pc4_mem_r   [DEPTH];
    logic [DW-1:0] instr_mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_nxt_s;

    assign push_s = in_valid && in_ready_r && !flush;
    assign pop_s  = out_valid_r && out_ready && !flush;

    // Next occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, occupancy and status-flag registers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CW{1'b0}});
            in_ready_r  <= (count_nxt_s != CW'(DEPTH));
        end
    end

    // Storage is deliberately left unreset; stale words are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            pc4_mem_r[wr_ptr_r]   <= in_pc4;
            instr_mem_r[wr_ptr_r] <= in_instr;
        end
    end

    // Head data falls through; an empty queue presents zeros so ID decodes a NOP.
    always_comb begin
        if (out_valid_r) begin
            out_pc4   = pc4_mem_r[rd_ptr_r];
            out_instr = instr_mem_r[rd_ptr_r];
        end else begin
            out_pc4   = {AW{1'b0}};
            out_instr = {DW{1'b0}};
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;

    pipe_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .count (count_r)
    );
endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Bench for pipe_fetch_queue: directed scenarios then random traffic against a queue model.
module tb_pipe_fetch_queue;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_pc4;
    logic [DW-1:0] in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc4;
    logic [DW-1:0] out_instr;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;
    logic [63:0] mq[$];

    pipe_fetch_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc4    (in_pc4),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'h0;
        chk({tag, ".count"},     64'(count),     64'(mq.size()));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() != DEPTH));
        chk({tag, ".out_pc4"},   64'(out_pc4),   64'(head[63:32]));
        chk({tag, ".out_instr"}, 64'(out_instr), 64'(head[31:0]));
    endtask

    // One clock: drive inputs, predict, advance, update model, compare.
    task automatic cycle(input string tag, input logic r, input logic iv, input logic [31:0] pc4,
                         input logic [31:0] instr, input logic fl, input logic ordy);
        bit m_push;
        bit m_pop;
        rst       = r;
        in_valid  = iv;
        in_pc4    = pc4;
        in_instr  = instr;
        flush     = fl;
        out_ready = ordy;
        m_push = iv && (mq.size() < DEPTH) && !fl && !r;
        m_pop  = ordy && (mq.size() != 0) && !fl && !r;
        @(posedge clk);
        #1;
        if (r || fl) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({pc4, instr});
        end
        check_model(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] fill_instr [4];
        logic [31:0] prev_instr;
        rst = 1'b1; in_valid = 1'b0; in_pc4 = 32'h0; in_instr = 32'h0;
        flush = 1'b0; out_ready = 1'b0;
        fill_instr[0] = 32'h20080005; fill_instr[1] = 32'h20090003;
        fill_instr[2] = 32'h01095020; fill_instr[3] = 32'hAC0A0000;
        @(negedge clk);

        cycle("reset", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset.out_instr_zero", 64'(out_instr), 64'h0);

        // Fill with ID stalled.
        for (int i = 0; i < 4; i++) begin
            cycle("fill", 1'b0, 1'b1, 32'((i + 1) * 4), fill_instr[i], 1'b0, 1'b0);
            chk("fill.count", 64'(count), 64'(i + 1));
            chk("fill.head", 64'(out_instr), 64'h20080005);
        end
        chk("fill.in_ready_low", 64'(in_ready), 64'h0);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk("drain.head", 64'(out_instr), 64'(fill_instr[i]));
            cycle("drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        chk("drain.empty_instr", 64'(out_instr), 64'h0);

        // Wrap-around streaming.
        for (int k = 1; k <= 10; k++) begin
            prev_instr = out_instr;
            cycle("stream", 1'b0, 1'b1, 32'(4 * k), 32'(k), 1'b0, 1'b1);
            chk("stream.count1", 64'(count), 64'h1);
            if (k > 1) chk("stream.incr", 64'(out_instr), 64'(prev_instr + 32'd1));
        end
        cycle("stream_drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Full plus simultaneous pop: the push is blocked.
        for (int i = 0; i < 4; i++) cycle("refill", 1'b0, 1'b1, 32'(16 + 4 * i), 32'(100 + i), 1'b0, 1'b0);
        cycle("full_pop", 1'b0, 1'b1, 32'h77, 32'hDEAD, 1'b0, 1'b1);
        chk("full_pop.count3", 64'(count), 64'h3);
        cycle("after_full_push", 1'b0, 1'b1, 32'h78, 32'hBEEF, 1'b0, 1'b0);
        chk("after_full_push.count4", 64'(count), 64'h4);

        // Flush with 3 entries and coincident push/pop.
        cycle("pre_flush", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle("flush", 1'b0, 1'b1, 32'h99, 32'h1234, 1'b1, 1'b1);
        chk("flush.count0", 64'(count), 64'h0);
        chk("flush.in_ready", 64'(in_ready), 64'h1);
        cycle("post_flush_push", 1'b0, 1'b1, 32'h44, 32'h08000010, 1'b0, 1'b0);
        chk("post_flush_push.head", 64'(out_instr), 64'h08000010);

        // Reset mid-operation.
        cycle("pre_rst", 1'b0, 1'b1, 32'h48, 32'h55, 1'b0, 1'b0);
        cycle("mid_rst", 1'b1, 1'b1, 32'h4C, 32'h66, 1'b0, 1'b0);
        chk("mid_rst.count0", 64'(count), 64'h0);
        for (int i = 0; i < 3; i++) cycle("post_rst_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(63) == 0), $urandom_range(1) == 1, $urandom, $urandom,
                  ($urandom_range(15) == 0), $urandom_range(2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
